// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_seq_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 20;

  localparam logic OPSEL_ADDSUB = 1'b0;
  localparam logic OPSEL_SHIFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_HOLD
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0] op1;
    logic [OP_W-1:0] op2;
    logic            opsel;
    logic            sign;
  } alu_cmd_t;

endpackage

// File: rtl/alu_golden_model.sv
// Reference result for one ALU command; only exists when SELF_CHECK_EN is defined.
// Latency: combinational.
// Backpressure: none.
`ifdef SELF_CHECK_EN
module alu_golden_model
  import alu_seq_pkg::*;
(
  input  alu_cmd_t         cmd,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = RES_W'(cmd.op1);
  assign b_ext = RES_W'(cmd.op2);

  // Add/sub wrap in 20-bit two's complement; shifts zero-extend op1 first so 15<<15 fits.
  always_comb begin
    result = '0;
    if (cmd.opsel == OPSEL_ADDSUB) begin
      result = cmd.sign ? (a_ext - b_ext) : (a_ext + b_ext);
    end else begin
      result = cmd.sign ? (a_ext >> cmd.op2) : (a_ext << cmd.op2);
    end
  end

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command at a time: drive operands, settle, capture result, hand it downstream.
// Latency: cmd accept -> res_valid = SETTLE_CYC+2 cycles; one result per SETTLE_CYC+3 with res_ready held high.
// Backpressure: cmd_ready low while a command is in flight; result held in HOLD until res_ready (SELF_CHECK_EN adds golden check).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op1,
  input  logic [OP_W-1:0]  cmd_op2,
  input  logic             cmd_opsel,
  input  logic             cmd_sign,
  output logic [OP_W-1:0]  alu_op1,
  output logic [OP_W-1:0]  alu_op2,
  output logic             alu_operation,
  output logic             alu_sign,
  input  logic [RES_W-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_mismatch,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int SC_W = 4;

  seq_state_t      state;
  seq_state_t      state_nxt;
  logic [SC_W-1:0] settle_cnt;
  alu_cmd_t        cmd_q;
  logic            accept;
  logic            deliver;
  logic            mismatch;

  assign cmd_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_HOLD);
  assign accept    = cmd_valid & cmd_ready;
  assign deliver   = res_valid & res_ready;

  // Operands stay on the ALU pins after delivery until the next command replaces them.
  assign alu_op1       = cmd_q.op1;
  assign alu_op2       = cmd_q.op2;
  assign alu_operation = cmd_q.opsel;
  assign alu_sign      = cmd_q.sign;

`ifdef SELF_CHECK_EN
  logic [RES_W-1:0] golden_res;

  alu_golden_model u_golden (
    .cmd    (cmd_q),
    .result (golden_res)
  );

  assign mismatch = (alu_result != golden_res);
`else
  assign mismatch = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one command in flight, settle countdown, single capture cycle, hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = ST_DRIVE;
      ST_DRIVE:   if (settle_cnt == '0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_HOLD;
      ST_HOLD:    if (res_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, settle counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      settle_cnt   <= '0;
      res_data     <= '0;
      res_mismatch <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q      <= '{op1: cmd_op1, op2: cmd_op2, opsel: cmd_opsel, sign: cmd_sign};
        settle_cnt <= SC_W'(SETTLE_CYC - 1);
      end else if (state == ST_DRIVE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SC_W'(1);
      end
      if (state == ST_CAPTURE) begin
        res_data     <= alu_result;
        res_mismatch <= mismatch;
      end
    end
  end

  // Delivered-result counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (deliver && op_count != '1) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

`ifdef SELF_CHECK_EN
  // Delivered-mismatch counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (deliver && res_mismatch && err_count != '1) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule
